// File: rtl/mac_weight_loader.sv
// mac_weight_loader: streams N ternary weight codes into a shadow bank and
// swaps them into the active bank in one step, so the MAC crossbar never
// sees a partially loaded vector.
// Optional build macro: MAC_WLOAD_ENC_CHECK_EN turns on the sticky enc_err
// flag for the reserved code 2'b10. Without it enc_err stays 0.
module mac_weight_loader #(
    parameter int N = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       w_valid,
    input  logic [1:0]                 w_data,
    output logic                       w_ready,
    output logic                       busy,
    output logic                       commit_done,
    output logic [$clog2(N+1)-1:0]     load_count,
    output logic                       enc_err,
    output real                        weights [N-1:0]
);

    localparam int CW = $clog2(N+1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Weights are held as 2-bit codes: 01 = +1, 11 = -1, 00 = 0.
    // The reserved code 10 is folded to 00 before it is stored.
    function automatic logic [1:0] map_code(input logic [1:0] code);
        logic [1:0] res;
        case (code)
            2'b01:   res = 2'b01;
            2'b11:   res = 2'b11;
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    function automatic real code_to_real(input logic [1:0] code);
        real res;
        case (code)
            2'b01:   res = 1.0;
            2'b11:   res = -1.0;
            default: res = 0.0;
        endcase
        return res;
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          load_count_q, load_count_d;
    logic [N-1:0][1:0]      shadow_q, shadow_d;
    logic [N-1:0][1:0]      active_q, active_d;
    logic                   commit_done_q, commit_done_d;
    logic                   enc_err_q, enc_err_d;
    logic                   w_ready_q, w_ready_d;
    logic                   busy_q, busy_d;

    // Next-state, bank update and flag computation for the load FSM.
    always_comb begin
        state_d       = state_q;
        load_count_d  = load_count_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        commit_done_d = 1'b0;
        enc_err_d     = enc_err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    load_count_d = '0;
                    shadow_d     = '0;
                    enc_err_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // abort has priority over a beat presented in the same cycle
                if (abort) begin
                    state_d      = S_IDLE;
                    load_count_d = '0;
                    shadow_d     = '0;
                end else if (w_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (load_count_q == CW'(i)) begin
                            shadow_d[i] = map_code(w_data);
                        end else begin
                            shadow_d[i] = shadow_q[i];
                        end
                    end
                    load_count_d = load_count_q + CW'(1);
                    if (load_count_q == CW'(N - 1)) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_LOAD;
                    end
`ifdef MAC_WLOAD_ENC_CHECK_EN
                    if (w_data == 2'b10) begin
                        enc_err_d = 1'b1;
                    end else begin
                        enc_err_d = enc_err_q;
                    end
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_COMMIT: begin
                active_d      = shadow_q;
                commit_done_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MAC_WLOAD_ENC_CHECK_EN
        enc_err_d = enc_err_d;
`else
        enc_err_d = 1'b0;
`endif

        // status outputs are registered copies of the next state
        w_ready_d = (state_d == S_LOAD);
        busy_d    = (state_d != S_IDLE);
    end

    // State, banks and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            load_count_q  <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            commit_done_q <= 1'b0;
            enc_err_q     <= 1'b0;
            w_ready_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_count_q  <= load_count_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            commit_done_q <= commit_done_d;
            enc_err_q     <= enc_err_d;
            w_ready_q     <= w_ready_d;
            busy_q        <= busy_d;
        end
    end

    // Real-valued view of the active bank; changes only when active_q does.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            weights[i] = code_to_real(active_q[i]);
        end
    end

    assign w_ready     = w_ready_q;
    assign busy        = busy_q;
    assign commit_done = commit_done_q;
    assign load_count  = load_count_q;
    assign enc_err     = enc_err_q;

endmodule

// File: tb/tb_mac_weight_loader.sv
// Self-checking bench for mac_weight_loader: a table of short vectors,
// hand-written load/abort/reset/encoding sequences and a random phase, all
// compared cycle by cycle against a queue-based reference model.
module tb_mac_weight_loader;

    localparam int N  = 32;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          w_valid;
    logic [1:0]    w_data;
    logic          w_ready;
    logic          busy;
    logic          commit_done;
    logic [CW-1:0] load_count;
    logic          enc_err;
    real           weights [N-1:0];

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;

`ifdef MAC_WLOAD_ENC_CHECK_EN
    localparam bit ENC_ON = 1'b1;
`else
    localparam bit ENC_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    mac_weight_loader #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .busy        (busy),
        .commit_done (commit_done),
        .load_count  (load_count),
        .enc_err     (enc_err),
        .weights     (weights)
    );

    // ---------------- reference model ----------------
    bit  m_load;
    bit  m_commit;
    bit  m_done;
    bit  m_err;
    int  m_count;
    real m_q[$];
    real m_act [N];

    function automatic real code_val(input logic [1:0] c);
        if (c == 2'b01) return 1.0;
        if (c == 2'b11) return -1.0;
        return 0.0;
    endfunction

    function void model_reset();
        m_load = 1'b0; m_commit = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_count = 0;
        m_q.delete();
        for (int i = 0; i < N; i++) m_act[i] = 0.0;
    endfunction

    function void model_step(input bit st, input bit ab, input bit v, input logic [1:0] d);
        m_done = 1'b0;
        if (m_commit) begin
            for (int i = 0; i < N; i++) m_act[i] = m_q[i];
            m_done   = 1'b1;
            m_commit = 1'b0;
        end else if (m_load) begin
            if (ab) begin
                m_load = 1'b0;
                m_q.delete();
                m_count = 0;
            end else if (v) begin
                m_q.push_back(code_val(d));
                m_count = m_q.size();
                if (ENC_ON && d == 2'b10) m_err = 1'b1;
                if (m_q.size() == N) begin
                    m_load   = 1'b0;
                    m_commit = 1'b1;
                end
            end
        end else if (st) begin
            m_load  = 1'b1;
            m_count = 0;
            m_q.delete();
            m_err   = 1'b0;
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_r(input string name, input real act, input real exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %f expected %f", name, act, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        int bad;
        chk({tag, "_w_ready"}, longint'(w_ready), longint'(m_load));
        chk({tag, "_busy"}, longint'(busy), longint'(m_load | m_commit));
        chk({tag, "_commit_done"}, longint'(commit_done), longint'(m_done));
        chk({tag, "_load_count"}, longint'(load_count), longint'(m_count));
        chk({tag, "_enc_err"}, longint'(enc_err), longint'(m_err));
        bad = 0;
        for (int i = 0; i < N; i++) if (weights[i] != m_act[i]) bad++;
        chk({tag, "_weights_wrong"}, longint'(bad), 64'sd0);
    endtask

    task automatic cycle(input string tag, input bit st, input bit ab, input bit v, input logic [1:0] d);
        start = st; abort = ab; w_valid = v; w_data = d;
        model_step(st, ab, v, d);
        @(posedge clk);
        #1;
        if (commit_done) n_done++;
        compare_model(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic all_weights(input string name, input real exp);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) if (weights[i] != exp) bad++;
        chk(name, longint'(bad), 64'sd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         st;
        bit         ab;
        bit         v;
        logic [1:0] d;
        bit         e_rdy;
        bit         e_busy;
        int         e_cnt;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int accepted;
        int guard;
        int done_base;
        bit v;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 2};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 0};

        // reset state
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b0; w_data = 2'b00;
        model_reset();
        #12;
        compare_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors
        for (int i = 0; i < 11; i++) begin
            cycle("tbl", tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_rdy", i), longint'(w_ready), longint'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_busy", i), longint'(busy), longint'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_cnt", i), longint'(load_count), longint'(tbl[i].e_cnt));
        end
        all_weights("tbl_weights_zero", 0.0);

        // full alternating load, with start pulsed during LOAD and COMMIT
        done_base = n_done;
        cycle("alt", 1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < N; k++) begin
            cycle("alt", (k == 10), 1'b0, 1'b1, (k % 2 == 0) ? 2'b01 : 2'b11);
            chk("alt_count", longint'(load_count), longint'(k + 1));
        end
        chk("alt_no_done_yet", longint'(commit_done), 64'sd0);
        chk("alt_busy_commit", longint'(busy), 64'sd1);
        chk("alt_ready_commit", longint'(w_ready), 64'sd0);
        chk_r("alt_w31_old", weights[31], 0.0);
        cycle("alt", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("alt_done", longint'(commit_done), 64'sd1);
        chk("alt_busy_after", longint'(busy), 64'sd0);
        chk_r("alt_w0", weights[0], 1.0);
        chk_r("alt_w1", weights[1], -1.0);
        chk_r("alt_w31", weights[31], -1.0);
        idle("alt");
        chk("alt_done_drop", longint'(commit_done), 64'sd0);
        chk("alt_single_done", longint'(n_done - done_base), 64'sd1);

        // random w_valid, all +1
        done_base = n_done;
        cycle("rv", 1'b1, 1'b0, 1'b0, 2'b00);
        accepted = 0;
        guard = 0;
        while (accepted < N && guard < 1000) begin
            v = 1'($urandom_range(0, 1));
            cycle("rv", 1'b0, 1'b0, v, 2'b01);
            if (v) accepted++;
            chk("rv_count", longint'(load_count), longint'(accepted));
            guard++;
        end
        chk("rv_guard", longint'(guard < 1000), 64'sd1);
        idle("rv");
        idle("rv");
        chk("rv_single_done", longint'(n_done - done_base), 64'sd1);
        all_weights("rv_all_plus", 1.0);

        // abort with simultaneous beat after 10 beats
        done_base = n_done;
        cycle("ab", 1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 10; k++) cycle("ab", 1'b0, 1'b0, 1'b1, 2'b11);
        cycle("ab", 1'b0, 1'b1, 1'b1, 2'b11);
        chk("ab_count", longint'(load_count), 64'sd0);
        chk("ab_busy", longint'(busy), 64'sd0);
        idle("ab");
        idle("ab");
        chk("ab_no_done", longint'(n_done - done_base), 64'sd0);
        all_weights("ab_weights_kept", 1.0);

        // asynchronous reset after 20 beats
        done_base = n_done;
        cycle("rst", 1'b1, 1'b0, 1'b0, 2'b00);
        for (int k = 0; k < 20; k++) cycle("rst", 1'b0, 1'b0, 1'b1, 2'b11);
        #3;
        rst_n = 1'b0;
        model_reset();
        #2;
        compare_model("rst_async");
        all_weights("rst_weights_zero", 0.0);
        chk("rst_count", longint'(load_count), 64'sd0);
        #1;
        rst_n = 1'b1;
        cycle("rst", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("rst_restart_ready", longint'(w_ready), 64'sd1);
        chk("rst_restart_count", longint'(load_count), 64'sd0);
        chk("rst_no_done", longint'(n_done - done_base), 64'sd0);

        // reserved code on beat 5 (load already started above)
        for (int k = 0; k < N; k++) begin
            cycle("enc", 1'b0, 1'b0, 1'b1, (k == 5) ? 2'b10 : 2'b01);
            if (k == 5) chk("enc_err_set", longint'(enc_err), longint'(ENC_ON));
        end
        idle("enc");
        chk_r("enc_w5", weights[5], 0.0);
        chk_r("enc_w4", weights[4], 1.0);
        chk("enc_err_sticky", longint'(enc_err), longint'(ENC_ON));
        cycle("enc", 1'b1, 1'b0, 1'b0, 2'b00);
        chk("enc_err_clear", longint'(enc_err), 64'sd0);
        cycle("enc", 1'b0, 1'b1, 1'b0, 2'b00);

        // random phase
        for (int c = 0; c < 2000; c++) begin
            cycle("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_weight_loader.md
MAC_WEIGHT_LOADER -- requirements
Module: mac_weight_loader

Interface
REQ-001 SHALL have parameter N, default 32: number of ternary weights (crossbar rows) driven.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: request to begin loading a new weight vector.
REQ-005 SHALL have port abort, input, 1: cancel the load in progress.
REQ-006 SHALL have port w_valid, input, 1: w_data beat is valid.
REQ-007 SHALL have port w_data, input, 2: ternary code; 00 = 0, 01 = +1, 11 = -1, 10 = reserved.
REQ-008 SHALL have port w_ready, output, 1: loader accepts a beat.
REQ-009 SHALL have port busy, output, 1: high in LOAD or COMMIT.
REQ-010 SHALL have port commit_done, output, 1: one-cycle pulse when new weights become active.
REQ-011 SHALL have port load_count, output, $clog2(N+1): beats accepted in the current load.
REQ-012 SHALL have port enc_err, output, 1: sticky reserved-code flag.
REQ-013 SHALL have port weights, output, real [N-1:0]: active weights (-1.0, 0.0, +1.0) to the MAC crossbar.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD and COMMIT.
REQ-015 IDLE: w_ready = 0; start -> LOAD with load_count cleared to 0.
REQ-016 LOAD: w_ready = 1; a beat is accepted on a clk edge with w_valid && w_ready; beat k (0-based) is written to shadow[k]; load_count increments.
REQ-017 LOAD: acceptance of beat N-1 -> COMMIT; load_count then reads N.
REQ-018 COMMIT: lasts exactly one cycle with w_ready = 0; on its closing edge the shadow bank is copied to the active bank, commit_done = 1 for one cycle, and the FSM returns to IDLE.
REQ-019 Timing: weights SHALL change only in the cycle commit_done is high, which is one cycle after the edge accepting the last beat; partial loads never reach weights.
REQ-020 start SHALL be ignored in LOAD and COMMIT.
REQ-021 abort in LOAD SHALL return the FSM to IDLE, discard the shadow bank and leave weights unchanged; abort in IDLE or COMMIT SHALL be ignored.
REQ-022 Simultaneous abort and w_valid in LOAD: abort wins and the beat SHALL NOT be stored.
REQ-023 Mapping: 01 -> +1.0, 11 -> -1.0, 00 -> 0.0, 10 -> 0.0 (with REQ-029 applying when enabled).
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 Between commits, weights SHALL hold their value and produce no events on the real outputs.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, load_count 0, w_ready 0, busy 0, commit_done 0, enc_err 0, and all weights and shadow entries 0.0.
REQ-027 Reset asserted mid-LOAD or mid-COMMIT SHALL abandon the load with no commit_done pulse and the active bank at 0.0.
REQ-028 The first start after rst_n deasserts SHALL behave as from IDLE.

Configuration
REQ-029 With MAC_WLOAD_ENC_CHECK_EN defined: an accepted code 10 SHALL set enc_err (sticky until the next accepted start), be stored as 0.0 and count as a beat.
REQ-030 Without MAC_WLOAD_ENC_CHECK_EN: enc_err SHALL be tied 0 and code 10 silently treated as 0.

Verification
REQ-031 Reset, then start, then N=32 back-to-back beats alternating 01/11 -> commit_done 1 cycle after beat 31; weights[0] = +1.0, weights[1] = -1.0, ..., weights[31] = -1.0; busy low the following cycle.
REQ-032 w_valid toggled randomly with 32 beats of 01 -> load_count steps only on handshakes; commit_done occurs exactly once; all weights = +1.0.
REQ-033 Committed all +1.0, then start, 10 beats of 11, then abort together with w_valid -> IDLE, load_count 0, weights remain +1.0, no commit_done.
REQ-034 rst_n pulsed low asynchronously after 20 beats -> all outputs 0 and weights 0.0 before the next clk edge; no commit_done.
REQ-035 With MAC_WLOAD_ENC_CHECK_EN: beat 5 = 10 -> enc_err = 1 from that edge, weights[5] = 0.0 after commit, enc_err cleared on the next start; without the macro the same stimulus keeps enc_err = 0.
REQ-036 start pulsed during LOAD and during COMMIT -> no restart, load_count unaffected, a single commit_done.
